eth_lat_log_sched: RTL and testbench
====================================

ETH_LAT_LOG_SCHED -- requirements
Module: eth_lat_log_sched

Interface
REQ-001 Parameter NUM_REQ, default 2, number of latency-record requesters (2..8).
REQ-002 Parameter CNT_W, default 16, width of entry limit and status counters.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req_val  in  NUM_REQ  per-requester record strobe, fire-and-forget, no ready.
REQ-006 req_timestamp  in  NUM_REQ x PKT_TIMESTAMP_W  per-requester start timestamp.
REQ-007 ctrl_start  in  1  single-cycle pulse: clear counters, begin recording.
REQ-008 ctrl_stop  in  1  single-cycle pulse: stop capture, drain held entries.
REQ-009 ctrl_limit  in  CNT_W  max entries per run, 0 = unlimited; sampled on accepted ctrl_start.
REQ-010 log_wr_val  out  1  entry valid toward latency log.
REQ-011 log_wr_rdy  in  1  log accepts entry when val and rdy both high.
REQ-012 log_wr_entry  out  eth_latency_stats_struct  start_timestamp, end_timestamp.
REQ-013 log_wr_src  out  clog2(NUM_REQ)  requester index of log_wr_entry.
REQ-014 stat_state  out  2  current FSM state encoding.
REQ-015 stat_logged  out  CNT_W  entries written this run (handshakes).
REQ-016 stat_dropped  out  CNT_W  requests lost this run, saturating.

Function
REQ-017 Free-running PKT_TIMESTAMP_W counter shall increment every cycle in all states, wrapping to 0.
REQ-018 FSM states IDLE=0, RECORD=1, DRAIN=2, DONE=3.
REQ-019 IDLE/DONE: ctrl_start -> RECORD next cycle, clearing stat_logged, stat_dropped, grant count, slots; ctrl_stop ignored.
REQ-020 RECORD: ctrl_start ignored; ctrl_stop -> DRAIN.
REQ-021 Each requester owns one holding slot; in RECORD, req_val with slot empty, or slot granted same cycle, shall load {req_timestamp, current counter value} as {start,end}.
REQ-022 In RECORD, req_val with slot full and not granted that cycle shall be discarded and increment stat_dropped (saturate at all-ones).
REQ-023 In IDLE, DRAIN, DONE, req_val shall be discarded without counting.
REQ-024 Output register loads when empty or handshaking this cycle, from a full slot chosen round-robin, starting after the last granted index; reset pointer 0.
REQ-025 Grant shall be suppressed once grants this run equal nonzero limit; new captures still occur but count as dropped if slot full.
REQ-026 Latency: req_val at cycle N, slot empty, output empty, no contention -> log_wr_val high at N+2.
REQ-027 log_wr_val, log_wr_entry, log_wr_src shall hold stable until handshake.
REQ-028 stat_logged increments per handshake, saturating.
REQ-029 RECORD or DRAIN -> DONE when (limit nonzero and grants == limit and output empty) or (DRAIN and all slots and output empty).
REQ-030 Entering DONE via limit shall clear all slots; those entries are not counted as dropped.
REQ-031 Sustained throughput one entry per cycle while log_wr_rdy high.

Reset
REQ-032 rst_n low shall asynchronously force state IDLE, timestamp counter 0, slots empty, log_wr_val 0, log_wr_entry 0, log_wr_src 0, stat counters 0, RR pointer 0, stored limit 0.
REQ-033 Reset mid-transfer shall drop the pending entry; no handshake assumed.
REQ-034 Reset release shall be synchronized externally; first active edge after release is cycle 0.

Structure
REQ-035 eth_latency_stats_struct and PKT_TIMESTAMP_W shall come from existing shared latency-stats definitions; state enum shall live in a shared package eth_lat_log_pkg.
REQ-036 Round-robin arbiter shall be a sub-module eth_lat_log_rr_arb (request vector, advance, grant one-hot, grant index).

Verification
REQ-037 start(limit=0), req0 val with ts=0x10 at counter 0x20, rdy=1 -> entry {0x10,0x20}, src 0, val two cycles later, stat_logged=1.
REQ-038 Both requesters strobe every cycle, rdy=1 -> alternating src 0,1, no drops, one entry per cycle.
REQ-039 rdy=0 for 5 cycles, req0 strobes every cycle -> slot holds first, stat_dropped=3 (slot free capture after output load), output stable.
REQ-040 start(limit=3), continuous requests -> exactly 3 handshakes, state DONE, further req_val ignored.
REQ-041 stop with two slots full, rdy toggling -> DRAIN, both entries written, then DONE, no new captures.
REQ-042 rst_n pulsed low mid-RECORD with log_wr_val high -> all outputs 0 immediately, IDLE, counter restarts at 0.

Source files
------------

// File: rtl/eth_lat_log_pkg.sv
// ---------------------------------------------------------------------------
// eth_lat_log_pkg
// Shared definitions for the latency-record scheduler:
//   PKT_TIMESTAMP_W          width of packet timestamps
//   eth_latency_stats_struct {start_timestamp, end_timestamp} log entry
//   lat_log_state_e          scheduler FSM state encoding (visible on stat_state)
//   popcount8                count of set bits in an 8-bit vector
// ---------------------------------------------------------------------------
package eth_lat_log_pkg;

    localparam int PKT_TIMESTAMP_W = 32;

    typedef struct packed {
        logic [PKT_TIMESTAMP_W-1:0] start_timestamp;
        logic [PKT_TIMESTAMP_W-1:0] end_timestamp;
    } eth_latency_stats_struct;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } lat_log_state_e;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/eth_lat_log_rr_arb.sv
// ---------------------------------------------------------------------------
// eth_lat_log_rr_arb
// Round-robin arbiter. Search starts one past the last granted index; the
// pointer only moves when the grant is actually consumed (advance).
// Ports:
//   clk, rst_n  clock, async active-low reset (pointer -> 0)
//   req         request vector
//   advance     current grant consumed this cycle
//   gnt         one-hot grant (zero when no request)
//   gnt_idx     index of granted requester
//   gnt_val     some request is granted
// ---------------------------------------------------------------------------
module eth_lat_log_rr_arb #(
    parameter int  N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_val
);

    localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N);

    logic [IDX_W-1:0] last_r;

    // Priority search from last_r+1 around the ring, first hit wins.
    always_comb begin
        logic [IDX_W:0]   pos_v;
        logic [IDX_W-1:0] idx_v;
        logic             hit_v;
        gnt_val = 1'b0;
        gnt_idx = {IDX_W{1'b0}};
        gnt     = {N{1'b0}};
        for (int k = 1; k <= N; k++) begin
            pos_v   = {1'b0, last_r} + (IDX_W+1)'(k);
            pos_v   = (pos_v >= N_L) ? (pos_v - N_L) : pos_v;
            idx_v   = pos_v[IDX_W-1:0];
            hit_v   = req[idx_v] && !gnt_val;
            gnt_idx = hit_v ? idx_v : gnt_idx;
            gnt_val = gnt_val | hit_v;
        end
        gnt[gnt_idx] = gnt_val;
    end

    // Last-granted pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= {IDX_W{1'b0}};
        end else if (advance) begin
            last_r <= gnt_idx;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/eth_lat_log_sched.sv
// ---------------------------------------------------------------------------
// eth_lat_log_sched
// Collects per-requester latency records into one holding slot each and
// schedules them round-robin into a single registered log write port.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_val/req_timestamp      per-requester record strobe + start timestamp
//   ctrl_start/ctrl_stop       run control pulses; ctrl_limit = max entries (0 = unlimited)
//   log_wr_val/rdy/entry/src   valid/ready log write port
//   stat_state/logged/dropped  FSM state and run statistics
// ---------------------------------------------------------------------------
module eth_lat_log_sched
    import eth_lat_log_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    parameter int  CNT_W   = 16,
    localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_REQ-1:0]                      req_val,
    input  logic [NUM_REQ-1:0][PKT_TIMESTAMP_W-1:0] req_timestamp,
    input  logic                                    ctrl_start,
    input  logic                                    ctrl_stop,
    input  logic [CNT_W-1:0]                        ctrl_limit,
    output logic                                    log_wr_val,
    input  logic                                    log_wr_rdy,
    output eth_latency_stats_struct                 log_wr_entry,
    output logic [SRC_W-1:0]                        log_wr_src,
    output logic [1:0]                              stat_state,
    output logic [CNT_W-1:0]                        stat_logged,
    output logic [CNT_W-1:0]                        stat_dropped
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PKT_TIMESTAMP_W-1:0] ts_cnt_r;
    lat_log_state_e             state_r;
    logic [CNT_W-1:0]           limit_r;
    logic [CNT_W-1:0]           grant_cnt_r;
    logic [CNT_W-1:0]           logged_r;
    logic [CNT_W-1:0]           dropped_r;
    logic [NUM_REQ-1:0]         slot_full_r;
    eth_latency_stats_struct    slot_entry_r [NUM_REQ];
    logic                       out_val_r;
    eth_latency_stats_struct    out_entry_r;
    logic [SRC_W-1:0]           out_src_r;

    logic               in_run_s, rec_s, start_s, limit_hit_s, hs_s;
    logic               advance_s, done_s, limit_done_s;
    logic [NUM_REQ-1:0] arb_gnt_s, gnt_hit_s, capture_s, drop_s;
    logic [SRC_W-1:0]   arb_idx_s;
    logic               arb_found_s;
    logic [3:0]         drop_cnt_s;
    logic [CNT_W:0]     dropped_sum_s;
    logic [CNT_W-1:0]   dropped_next_s;

    eth_lat_log_rr_arb #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (slot_full_r),
        .advance (advance_s),
        .gnt     (arb_gnt_s),
        .gnt_idx (arb_idx_s),
        .gnt_val (arb_found_s)
    );

    assign in_run_s    = (state_r == ST_RECORD) || (state_r == ST_DRAIN);
    assign rec_s       = (state_r == ST_RECORD);
    assign start_s     = ctrl_start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign limit_hit_s = (limit_r != {CNT_W{1'b0}}) && (grant_cnt_r == limit_r);
    assign hs_s        = out_val_r && log_wr_rdy;
    // Output register may take a new entry when empty or being emptied now.
    assign advance_s   = in_run_s && !limit_hit_s && (!out_val_r || log_wr_rdy) && arb_found_s;
    assign gnt_hit_s   = advance_s ? arb_gnt_s : {NUM_REQ{1'b0}};
    assign done_s      = in_run_s && !out_val_r &&
                         (limit_hit_s || ((state_r == ST_DRAIN) && (slot_full_r == {NUM_REQ{1'b0}})));
    assign limit_done_s = done_s && limit_hit_s;

    // Per-slot capture/drop decision; a slot granted this cycle is free to reload.
    always_comb begin
        capture_s = {NUM_REQ{1'b0}};
        drop_s    = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            capture_s[i] = rec_s && req_val[i] && (!slot_full_r[i] || gnt_hit_s[i]);
            drop_s[i]    = rec_s && req_val[i] && slot_full_r[i] && !gnt_hit_s[i];
        end
    end

    assign drop_cnt_s     = popcount8(8'(drop_s));
    assign dropped_sum_s  = {1'b0, dropped_r} + (CNT_W+1)'(drop_cnt_s);
    assign dropped_next_s = dropped_sum_s[CNT_W] ? CNT_MAX : dropped_sum_s[CNT_W-1:0];

    assign log_wr_val   = out_val_r;
    assign log_wr_entry = out_entry_r;
    assign log_wr_src   = out_src_r;
    assign stat_state   = state_r;
    assign stat_logged  = logged_r;
    assign stat_dropped = dropped_r;

    // Free-running timestamp counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt_r <= {PKT_TIMESTAMP_W{1'b0}};
        end else begin
            ts_cnt_r <= ts_cnt_r + PKT_TIMESTAMP_W'(1);
        end
    end

    // Run-control FSM; limit is latched only on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            limit_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (ctrl_start) begin
                        state_r <= ST_RECORD;
                        limit_r <= ctrl_limit;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RECORD: begin
                    if (done_s) begin
                        state_r <= ST_DONE;
                    end else if (ctrl_stop) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_RECORD;
                    end
                end
                ST_DRAIN: begin
                    if (done_s) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Run statistics and grant counter, all saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            logged_r    <= {CNT_W{1'b0}};
            dropped_r   <= {CNT_W{1'b0}};
            grant_cnt_r <= {CNT_W{1'b0}};
        end else if (start_s) begin
            logged_r    <= {CNT_W{1'b0}};
            dropped_r   <= {CNT_W{1'b0}};
            grant_cnt_r <= {CNT_W{1'b0}};
        end else begin
            logged_r    <= (hs_s && (logged_r != CNT_MAX)) ? logged_r + CNT_ONE : logged_r;
            dropped_r   <= dropped_next_s;
            grant_cnt_r <= (advance_s && (grant_cnt_r != CNT_MAX)) ? grant_cnt_r + CNT_ONE : grant_cnt_r;
        end
    end

    // Holding slots; a limit-terminated run discards what is still held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_full_r <= {NUM_REQ{1'b0}};
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_entry_r[i] <= {(2*PKT_TIMESTAMP_W){1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (start_s || limit_done_s) begin
                    slot_full_r[i] <= 1'b0;
                end else if (capture_s[i]) begin
                    slot_full_r[i]                  <= 1'b1;
                    slot_entry_r[i].start_timestamp <= req_timestamp[i];
                    slot_entry_r[i].end_timestamp   <= ts_cnt_r;
                end else if (gnt_hit_s[i]) begin
                    slot_full_r[i] <= 1'b0;
                end else begin
                    slot_full_r[i] <= slot_full_r[i];
                end
            end
        end
    end

    // Output register; contents held stable until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val_r   <= 1'b0;
            out_entry_r <= {(2*PKT_TIMESTAMP_W){1'b0}};
            out_src_r   <= {SRC_W{1'b0}};
        end else if (advance_s) begin
            out_val_r   <= 1'b1;
            out_entry_r <= slot_entry_r[arb_idx_s];
            out_src_r   <= arb_idx_s;
        end else if (hs_s) begin
            out_val_r   <= 1'b0;
        end else begin
            out_val_r   <= out_val_r;
        end
    end

endmodule

// File: tb/tb_eth_lat_log_sched.sv
// ---------------------------------------------------------------------------
// tb_eth_lat_log_sched
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_eth_lat_log_sched;
    import eth_lat_log_pkg::*;

    localparam int N    = 2;
    localparam int CW   = 16;
    localparam int CMAX = 65535;

    logic                                  clk = 1'b0;
    logic                                  rst_n = 1'b0;
    logic [N-1:0]                          req_val = '0;
    logic [N-1:0][PKT_TIMESTAMP_W-1:0]     req_timestamp = '0;
    logic                                  ctrl_start = 1'b0;
    logic                                  ctrl_stop = 1'b0;
    logic [CW-1:0]                         ctrl_limit = '0;
    logic                                  log_wr_val;
    logic                                  log_wr_rdy = 1'b0;
    eth_latency_stats_struct               log_wr_entry;
    logic [0:0]                            log_wr_src;
    logic [1:0]                            stat_state;
    logic [CW-1:0]                         stat_logged;
    logic [CW-1:0]                         stat_dropped;

    eth_lat_log_sched #(.NUM_REQ(N), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_val       (req_val),
        .req_timestamp (req_timestamp),
        .ctrl_start    (ctrl_start),
        .ctrl_stop     (ctrl_stop),
        .ctrl_limit    (ctrl_limit),
        .log_wr_val    (log_wr_val),
        .log_wr_rdy    (log_wr_rdy),
        .log_wr_entry  (log_wr_entry),
        .log_wr_src    (log_wr_src),
        .stat_state    (stat_state),
        .stat_logged   (stat_logged),
        .stat_dropped  (stat_dropped)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_state, m_logged, m_dropped, m_grants, m_limit, m_last, m_osrc;
    logic [31:0] m_cnt;
    bit          m_full [N];
    logic [31:0] m_sstart [N];
    logic [31:0] m_send [N];
    bit          m_oval;
    logic [31:0] m_ostart, m_oend;

    task automatic model_reset();
        m_state = 0; m_logged = 0; m_dropped = 0; m_grants = 0; m_limit = 0;
        m_last = 0; m_osrc = 0; m_cnt = 32'd0; m_oval = 1'b0;
        m_ostart = 32'd0; m_oend = 32'd0;
        for (int i = 0; i < N; i++) m_full[i] = 1'b0;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        bit run, lim_hit, hs, any_full, done;
        int g, idx;
        run     = (m_state == 1) || (m_state == 2);
        lim_hit = (m_limit != 0) && (m_grants == m_limit);
        hs      = m_oval && log_wr_rdy;
        any_full = 1'b0;
        for (int i = 0; i < N; i++) any_full |= m_full[i];
        done = run && !m_oval && (lim_hit || (m_state == 2 && !any_full));
        g = -1;
        if (run && !lim_hit && (!m_oval || log_wr_rdy)) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (g < 0 && m_full[idx]) g = idx;
            end
        end
        if (hs && m_logged < CMAX) m_logged++;
        if (g >= 0) begin
            m_oval = 1'b1; m_ostart = m_sstart[g]; m_oend = m_send[g];
            m_osrc = g; m_last = g; m_full[g] = 1'b0;
            if (m_grants < CMAX) m_grants++;
        end else if (hs) begin
            m_oval = 1'b0;
        end
        // A slot emptied by this cycle's grant is already marked free here.
        if (m_state == 1) begin
            for (int i = 0; i < N; i++) begin
                if (req_val[i]) begin
                    if (!m_full[i]) begin
                        m_full[i] = 1'b1; m_sstart[i] = req_timestamp[i]; m_send[i] = m_cnt;
                    end else if (m_dropped < CMAX) begin
                        m_dropped++;
                    end
                end
            end
        end
        if (m_state == 0 || m_state == 3) begin
            if (ctrl_start) begin
                m_state = 1; m_logged = 0; m_dropped = 0; m_grants = 0;
                m_limit = int'(ctrl_limit);
                for (int i = 0; i < N; i++) m_full[i] = 1'b0;
            end
        end else if (done) begin
            m_state = 3;
            if (lim_hit) for (int i = 0; i < N; i++) m_full[i] = 1'b0;
        end else if (m_state == 1 && ctrl_stop) begin
            m_state = 2;
        end
        m_cnt = m_cnt + 32'd1;
    endtask

    task automatic compare_all();
        check_eq("state",   64'(stat_state),   64'(m_state));
        check_eq("logged",  64'(stat_logged),  64'(m_logged));
        check_eq("dropped", 64'(stat_dropped), 64'(m_dropped));
        check_eq("val",     64'(log_wr_val),   64'(m_oval));
        if (m_oval) begin
            check_eq("entry", 64'(log_wr_entry), {m_ostart, m_oend});
            check_eq("src",   64'(log_wr_src),   64'(m_osrc));
        end
    endtask

    task automatic compare_reset(input string tag);
        check_eq({tag, "_val"},     64'(log_wr_val),   64'd0);
        check_eq({tag, "_entry"},   64'(log_wr_entry), 64'd0);
        check_eq({tag, "_src"},     64'(log_wr_src),   64'd0);
        check_eq({tag, "_state"},   64'(stat_state),   64'd0);
        check_eq({tag, "_logged"},  64'(stat_logged),  64'd0);
        check_eq({tag, "_dropped"}, 64'(stat_dropped), 64'd0);
    endtask

    task automatic idle_inputs();
        req_val = '0; ctrl_start = 1'b0; ctrl_stop = 1'b0;
    endtask

    // One clock: model consumes the driven inputs, DUT checked on the falling edge.
    task automatic tick();
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset; outputs checked before any clock edge.
    task automatic do_reset(input string tag);
        #1 rst_n = 1'b0;
        model_reset();
        #1 compare_reset(tag);
        @(negedge clk);
        @(negedge clk);
        compare_reset({tag, "_hold"});
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic start_run(input int lim);
        ctrl_start = 1'b1; ctrl_limit = CW'(lim);
        tick();
        ctrl_start = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        int guard;
        req_val = '0; log_wr_rdy = 1'b1; ctrl_stop = 1'b1;
        tick();
        ctrl_stop = 1'b0;
        guard = 0;
        while (m_state != 3 && guard < 40) begin
            tick();
            guard++;
        end
        check_eq({tag, "_done"}, 64'(stat_state), 64'd3);
    endtask

    task automatic rand_ts();
        for (int i = 0; i < N; i++) req_timestamp[i] = $urandom;
    endtask

    initial begin
        int guard;
        model_reset();
        do_reset("rst0");

        // Single record: ts 0x10 captured at counter 0x20, visible two cycles later.
        start_run(0);
        guard = 0;
        while (m_cnt != 32'h20 && guard < 100) begin tick(); guard++; end
        req_val = 2'b01; req_timestamp[0] = 32'h10; log_wr_rdy = 1'b1;
        tick();
        req_val = '0;
        check_eq("lat_n1", 64'(log_wr_val), 64'd0);
        tick();
        check_eq("lat_n2_val",   64'(log_wr_val),   64'd1);
        check_eq("lat_n2_entry", 64'(log_wr_entry), {32'h10, 32'h20});
        check_eq("lat_n2_src",   64'(log_wr_src),   64'd0);
        tick();
        check_eq("lat_logged", 64'(stat_logged), 64'd1);
        finish_run("single");

        // Both requesters every cycle with rdy high.
        start_run(0);
        req_val = 2'b11; log_wr_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin rand_ts(); tick(); end
        finish_run("both");

        // Back-pressure: slot holds, later strobes counted as dropped.
        start_run(0);
        log_wr_rdy = 1'b0; req_val = 2'b01;
        for (int c = 0; c < 5; c++) begin rand_ts(); tick(); end
        req_val = '0;
        check_eq("bp_dropped", 64'(stat_dropped), 64'd3);
        check_eq("bp_val",     64'(log_wr_val),   64'd1);
        tick(); tick();
        finish_run("bp");

        // Limit of three entries.
        start_run(3);
        req_val = 2'b11; log_wr_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin rand_ts(); tick(); end
        check_eq("lim_logged", 64'(stat_logged), 64'd3);
        check_eq("lim_state",  64'(stat_state),  64'd3);
        for (int c = 0; c < 4; c++) begin rand_ts(); tick(); end
        check_eq("lim_after", 64'(stat_logged), 64'd3);
        idle_inputs();

        // Stop with both slots and output full, rdy toggling, strobes ignored.
        start_run(0);
        log_wr_rdy = 1'b0; req_val = 2'b11;
        rand_ts(); tick();
        rand_ts(); tick();
        req_val = '0; ctrl_stop = 1'b1;
        tick();
        ctrl_stop = 1'b0;
        check_eq("drain_state", 64'(stat_state), 64'd2);
        guard = 0;
        while (m_state != 3 && guard < 40) begin
            log_wr_rdy = ~log_wr_rdy; req_val = N'($urandom); rand_ts();
            tick(); guard++;
        end
        check_eq("drain_done",   64'(stat_state),  64'd3);
        check_eq("drain_logged", 64'(stat_logged), 64'd3);
        idle_inputs();

        // Reset while an entry is pending on the log port.
        start_run(0);
        log_wr_rdy = 1'b0; req_val = 2'b01; rand_ts();
        tick();
        req_val = '0;
        tick(); tick();
        check_eq("pre_rst_val", 64'(log_wr_val), 64'd1);
        do_reset("midrst");
        start_run(0);
        req_val = 2'b10; log_wr_rdy = 1'b1; rand_ts();
        tick();
        req_val = '0;
        tick(); tick();
        check_eq("post_rst_end", 64'(log_wr_entry.end_timestamp), 64'd1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            ctrl_start = ($urandom_range(0, 39) == 0);
            ctrl_stop  = ($urandom_range(0, 39) == 0);
            ctrl_limit = ($urandom_range(0, 2) == 0) ? CW'($urandom_range(1, 5)) : CW'(0);
            log_wr_rdy = ($urandom_range(0, 3) != 0);
            req_val    = N'($urandom);
            rand_ts();
            if ($urandom_range(0, 999) == 0) begin
                do_reset("rnd_rst");
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
